// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: req/gnt/rvalid fetch into the instruction register plus field decode.
// Optional FETCH_TIMEOUT_EN adds a watchdog that faults a fetch stuck in REQ/RESP.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 32
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fetch_start,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [31:0]       i_imem_rdata,
  output logic [31:0]       o_ir,
  output logic [6:0]        o_opcode,
  output logic [4:0]        o_rd,
  output logic [2:0]        o_funct3,
  output logic [4:0]        o_rs1,
  output logic [4:0]        o_rs2,
  output logic [11:0]       o_funct12,
  output logic              o_ir_valid,
  output logic              o_fetch_busy,
  output logic              o_fault,
  output logic [1:0]        o_fault_cause
);

  localparam int unsigned DATA_W        = 32;
  localparam logic [DATA_W-1:0] IR_NOP  = 32'h0000_0013;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_ir;
  logic [1:0]          r_cause;
  logic                r_req;
  logic                r_busy;
  logic                r_valid;
  logic                r_fault;
  logic                w_accept;
  logic                w_capture;
  logic                w_misaligned;
  logic                w_timeout;

  assign w_misaligned = (i_pc[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;

  // Watchdog: cleared on entry to REQ, counts every cycle spent in REQ or RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept && !w_misaligned) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_RESP) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == S_REQ || r_state == S_RESP) &&
                     ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; timeout wins over a same-cycle gnt/rvalid
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE, S_HOLD, S_FAULT: begin
        if (i_fetch_start) begin
          w_accept     = 1'b1;
          w_state_next = w_misaligned ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          w_state_next = S_FAULT;
        end else if (i_imem_gnt) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_timeout) begin
          w_state_next = S_FAULT;
        end else if (i_imem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and status registers; status flags track the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_ir    <= IR_NOP;
      r_cause <= CAUSE_NONE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= i_pc;
        r_cause <= w_misaligned ? CAUSE_MISALIGN : CAUSE_NONE;
      end else if (w_timeout) begin
        r_cause <= CAUSE_TIMEOUT;
      end
      if (w_capture) begin
        r_ir <= i_imem_rdata;
      end
      r_req   <= (w_state_next == S_REQ);
      r_busy  <= (w_state_next == S_REQ) || (w_state_next == S_RESP);
      r_valid <= (w_state_next == S_HOLD);
      r_fault <= (w_state_next == S_FAULT);
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_ir          = r_ir;
  assign o_opcode      = r_ir[6:0];
  assign o_rd          = r_ir[11:7];
  assign o_funct3      = r_ir[14:12];
  assign o_rs1         = r_ir[19:15];
  assign o_rs2         = r_ir[24:20];
  assign o_funct12     = r_ir[31:20];
  assign o_ir_valid    = r_valid;
  assign o_fetch_busy  = r_busy;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_cause;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default build; FETCH_TIMEOUT_EN path optional).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] funct12;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .i_fetch_start(fetch_start),
    .i_pc         (pc),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .o_ir         (ir),
    .o_opcode     (opcode),
    .o_rd         (rd),
    .o_funct3     (funct3),
    .o_rs1        (rs1),
    .o_rs2        (rs2),
    .o_funct12    (funct12),
    .o_ir_valid   (ir_valid),
    .o_fetch_busy (fetch_busy),
    .o_fault      (fault),
    .o_fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    fetch_start = 1'b0;
    pc          = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_ir",      ir,          32'h0000_0013);
    chk("rst_opcode",  32'(opcode), 32'h13);
    chk("rst_valid",   32'(ir_valid), 32'd0);
    chk("rst_req",     32'(imem_req), 32'd0);
    chk("rst_fault",   32'(fault),  32'd0);
    chk("rst_cause",   32'(fault_cause), 32'd0);
    chk("rst_busy",    32'(fetch_busy), 32'd0);
    chk("rst_addr",    imem_addr,   32'h0);
    reset = 1'b0;
    tick();

    // Zero-wait aligned fetch at 0x100
    fetch_start = 1'b1; pc = 32'h100;
    tick();
    fetch_start = 1'b0;
    chk("f1_c1_req",   32'(imem_req), 32'd1);
    chk("f1_c1_addr",  imem_addr,   32'h100);
    chk("f1_c1_busy",  32'(fetch_busy), 32'd1);
    chk("f1_c1_valid", 32'(ir_valid), 32'd0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("f1_c2_req",   32'(imem_req), 32'd0);
    chk("f1_c2_busy",  32'(fetch_busy), 32'd1);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    chk("f1_c3_valid", 32'(ir_valid), 32'd1);
    chk("f1_c3_ir",    ir,          32'h00A0_0093);
    chk("f1_opcode",   32'(opcode), 32'h13);
    chk("f1_rd",       32'(rd),     32'd1);
    chk("f1_funct3",   32'(funct3), 32'd0);
    chk("f1_rs1",      32'(rs1),    32'd0);
    chk("f1_rs2",      32'(rs2),    32'd10);
    chk("f1_funct12",  32'(funct12), 32'h00A);
    chk("f1_busy",     32'(fetch_busy), 32'd0);
    tick();
    chk("f1_hold_valid", 32'(ir_valid), 32'd1);

    // Misaligned fetch from HOLD
    fetch_start = 1'b1; pc = 32'h102;
    tick();
    fetch_start = 1'b0;
    chk("mis_fault",   32'(fault),  32'd1);
    chk("mis_cause",   32'(fault_cause), 32'd1);
    chk("mis_req",     32'(imem_req), 32'd0);
    chk("mis_valid",   32'(ir_valid), 32'd0);
    chk("mis_addr",    imem_addr,   32'h102);
    chk("mis_ir_keep", ir,          32'h00A0_0093);
    tick();
    tick();
    chk("mis_persist", 32'(fault),  32'd1);
    chk("mis_req2",    32'(imem_req), 32'd0);

    // Retry with aligned pc from FAULT
    fetch_start = 1'b1; pc = 32'h104;
    tick();
    fetch_start = 1'b0;
    chk("retry_fault", 32'(fault),  32'd0);
    chk("retry_cause", 32'(fault_cause), 32'd0);
    chk("retry_req",   32'(imem_req), 32'd1);
    chk("retry_addr",  imem_addr,   32'h104);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_81B3;
    tick();
    imem_rvalid = 1'b0;
    chk("retry_ir",     ir,          32'h0020_81B3);
    chk("retry_opcode", 32'(opcode), 32'h33);
    chk("retry_rd",     32'(rd),     32'd3);
    chk("retry_rs1",    32'(rs1),    32'd1);
    chk("retry_rs2",    32'(rs2),    32'd2);

    // Stalled memory: gnt withheld 3 cycles with spurious rvalid in REQ
    fetch_start = 1'b1; pc = 32'h200;
    tick();
    fetch_start = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req",  32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr,   32'h200);
      tick();
    end
    chk("stall_ir_keep", ir,         32'h0020_81B3);
    chk("stall_req3",    32'(imem_req), 32'd1);
    // gnt with rvalid in the same cycle: rvalid must be ignored
    imem_gnt = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    chk("gnt_req",     32'(imem_req), 32'd0);
    chk("gnt_busy",    32'(fetch_busy), 32'd1);
    chk("gnt_valid",   32'(ir_valid), 32'd0);
    chk("gnt_ir_keep", ir,          32'h0020_81B3);
    // fetch_start during RESP is ignored
    fetch_start = 1'b1; pc = 32'h304;
    tick();
    fetch_start = 1'b0;
    chk("resp_busy",   32'(fetch_busy), 32'd1);
    chk("resp_addr",   imem_addr,   32'h200);
    chk("resp_fault",  32'(fault),  32'd0);
    chk("resp_req",    32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5237;
    tick();
    imem_rvalid = 1'b0;
    chk("stall_valid", 32'(ir_valid), 32'd1);
    chk("stall_ir",    ir,          32'h1234_5237);
    chk("stall_addr_end", imem_addr, 32'h200);

    // Long stall in REQ: 300 cycles without gnt
    fetch_start = 1'b1; pc = 32'h400;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 300; i++) tick();
`ifdef FETCH_TIMEOUT_EN
    chk("long_fault",  32'(fault),  32'd1);
    chk("long_cause",  32'(fault_cause), 32'd2);
    chk("long_req",    32'(imem_req), 32'd0);
    fetch_start = 1'b1; pc = 32'h400;
    tick();
    fetch_start = 1'b0;
`else
    chk("long_req",    32'(imem_req), 32'd1);
    chk("long_fault",  32'(fault),  32'd0);
    chk("long_addr",   imem_addr,   32'h400);
`endif

    // Reset in RESP, then a late rvalid
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("mid_in_resp", 32'(fetch_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_ir",      ir,          32'h0000_0013);
    chk("mid_req",     32'(imem_req), 32'd0);
    chk("mid_busy",    32'(fetch_busy), 32'd0);
    chk("mid_valid",   32'(ir_valid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_rvalid = 1'b0;
    chk("late_ir",     ir,          32'h0000_0013);
    chk("late_valid",  32'(ir_valid), 32'd0);
    chk("late_busy",   32'(fetch_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
